// File: rtl/ex_stage_pkg.sv
// Pipeline-wide shared definitions: datapath defaults, ALU op encodings,
// control-bundle bit positions and the EX-stage FSM state type.
package ex_stage_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_CTRL_W = 9;

  // Control bundle bit positions
  localparam int CTRL_DMEM_WE = 4;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_SEQ   = 4'd10,
    OP_SNE   = 4'd11,
    OP_PASSB = 4'd12,
    OP_MUL   = 4'd13
  } alu_op_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } ex_state_e;

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Radix-2 shift-add multiplier, one iteration per enabled cycle.
// Always runs exactly WIDTH iterations; product is the low WIDTH bits.
// 'product' is the accumulator including the current iteration, so it is
// the finished result in the cycle where 'done' is high.
module mul_iter
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [WIDTH-1:0] acc_nxt;

  // Partial-product add for the iteration in progress
  always_comb begin
    acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CNT_W'(WIDTH-1));
  assign product = acc_nxt;

  // Iteration state; frozen whenever en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (en) begin
      if (start) begin
        busy_q   <= 1'b1;
        cnt_q    <= '0;
        acc_q    <= '0;
        mcand_q  <= a;
        mplier_q <= b;
      end else if (busy_q) begin
        acc_q    <= acc_nxt;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= done ? '0 : cnt_q + 1'b1;
        busy_q   <= !done;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, iterative multiply, EX/MEM register.
// Stalls upstream while a multiply runs or the memory stage holds the pipe.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              in_valid,
  input  logic [3:0]        alu_op,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic [WIDTH-1:0]  store_data,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [2:0]        dmem_info,
  input  logic [4:0]        write_reg,
  output logic              stall_out,
  output logic              out_valid,
  output logic [CTRL_W-1:0] ctrl_reg,
  output logic [WIDTH-1:0]  alu_out_reg,
  output logic [WIDTH-1:0]  write_data_reg,
  output logic [2:0]        dmem_info_reg,
  output logic [4:0]        write_reg_reg
);

  ex_state_e state_q, state_d;

  logic [WIDTH-1:0] alu_res;
  logic [4:0]       shamt;
  logic             is_mul, mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_prod;

  logic              valid_q,   valid_d;
  logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
  logic [WIDTH-1:0]  alu_q,     alu_d;
  logic [WIDTH-1:0]  wdata_q,   wdata_d;
  logic [2:0]        info_q,    info_d;
  logic [4:0]        wreg_q,    wreg_d;

  assign shamt     = op_b[4:0];
  assign is_mul    = (alu_op == OP_MUL);
  assign mul_start = (state_q == ST_IDLE) && in_valid && is_mul;

  // Single-cycle ALU; MUL and undefined encodings yield 0 here
  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:   alu_res = op_a + op_b;
      OP_SUB:   alu_res = op_a - op_b;
      OP_AND:   alu_res = op_a & op_b;
      OP_OR:    alu_res = op_a | op_b;
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_SLL:   alu_res = op_a << shamt;
      OP_SRL:   alu_res = op_a >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_SEQ:   alu_res = {{(WIDTH-1){1'b0}}, (op_a == op_b)};
      OP_SNE:   alu_res = {{(WIDTH-1){1'b0}}, (op_a != op_b)};
      OP_PASSB: alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (!hold),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Stall: downstream hold, a multiply being launched, or one still iterating
  assign stall_out = hold || mul_start ||
                     ((state_q == ST_MUL_RUN) && mul_busy && !mul_done);

  // Next state and next EX/MEM contents; a bubble unless a result retires
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    ctrl_d  = '0;
    alu_d   = '0;
    wdata_d = '0;
    info_d  = '0;
    wreg_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (mul_start) begin
          state_d = ST_MUL_RUN;
        end else if (in_valid) begin
          valid_d = 1'b1;
          ctrl_d  = ctrl;
          alu_d   = alu_res;
          wdata_d = store_data;
          info_d  = dmem_info;
          wreg_d  = write_reg;
        end
      end
      ST_MUL_RUN: begin
        if (mul_done) begin
          state_d = ST_IDLE;
          valid_d = 1'b1;
          ctrl_d  = ctrl;
          alu_d   = mul_prod;
          wdata_d = store_data;
          info_d  = dmem_info;
          wreg_d  = write_reg;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and EX/MEM register; everything freezes under hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      alu_q   <= '0;
      wdata_q <= '0;
      info_q  <= '0;
      wreg_q  <= '0;
    end else if (!hold) begin
      state_q <= state_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      alu_q   <= alu_d;
      wdata_q <= wdata_d;
      info_q  <= info_d;
      wreg_q  <= wreg_d;
    end
  end

  assign out_valid      = valid_q;
  assign ctrl_reg       = ctrl_q;
  assign alu_out_reg    = alu_q;
  assign write_data_reg = wdata_q;
  assign dmem_info_reg  = info_q;
  assign write_reg_reg  = wreg_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ex_stage;

  localparam int W  = 32;
  localparam int CW = 9;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SRA = 4'd7, SLT = 4'd8,
                         SLTU = 4'd9, MUL = 4'd13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hold = 1'b0;
  logic          in_valid = 1'b0;
  logic [3:0]    alu_op = '0;
  logic [W-1:0]  op_a = '0, op_b = '0, store_data = '0;
  logic [CW-1:0] ctrl = '0;
  logic [2:0]    dmem_info = '0;
  logic [4:0]    write_reg = '0;
  logic          stall_out, out_valid;
  logic [CW-1:0] ctrl_reg;
  logic [W-1:0]  alu_out_reg, write_data_reg;
  logic [2:0]    dmem_info_reg;
  logic [4:0]    write_reg_reg;

  ex_stage #(.WIDTH(W), .CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .in_valid(in_valid),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .store_data(store_data),
    .ctrl(ctrl), .dmem_info(dmem_info), .write_reg(write_reg),
    .stall_out(stall_out), .out_valid(out_valid), .ctrl_reg(ctrl_reg),
    .alu_out_reg(alu_out_reg), .write_data_reg(write_data_reg),
    .dmem_info_reg(dmem_info_reg), .write_reg_reg(write_reg_reg)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A multiply is "pending" for a number of remaining MUL_RUN edges; the
  // product is simply op_a*op_b taken when the multiply is launched.
  bit            m_busy;
  int            m_rem;
  logic [W-1:0]  m_prod;
  logic          e_valid;
  logic [CW-1:0] e_ctrl;
  logic [W-1:0]  e_alu, e_wd;
  logic [2:0]    e_info;
  logic [4:0]    e_wr;

  function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sh;
    longint sa, sb;
    sh = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return W'(sa >>> sh);
      8:  return (sa < sb) ? 1 : 0;
      9:  return (a < b) ? 1 : 0;
      10: return (a == b) ? 1 : 0;
      11: return (a != b) ? 1 : 0;
      12: return b;
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    m_busy = 0; m_rem = 0; m_prod = 0;
    e_valid = 0; e_ctrl = 0; e_alu = 0; e_wd = 0; e_info = 0; e_wr = 0;
  endtask

  task automatic m_load(input logic [W-1:0] res);
    e_valid = 1; e_ctrl = ctrl; e_alu = res; e_wd = store_data;
    e_info = dmem_info; e_wr = write_reg;
  endtask

  task automatic m_bubble();
    e_valid = 0; e_ctrl = 0; e_alu = 0; e_wd = 0; e_info = 0; e_wr = 0;
  endtask

  function automatic bit m_stall();
    return hold || (!m_busy && in_valid && alu_op == MUL) || (m_busy && m_rem != 1);
  endfunction

  task automatic m_step();
    if (hold) return;
    if (!m_busy) begin
      if (in_valid && alu_op == MUL) begin
        m_busy = 1; m_rem = W;
        m_prod = W'(64'(op_a) * 64'(op_b));
        m_bubble();
      end else if (in_valid) m_load(alu_ref(alu_op, op_a, op_b));
      else m_bubble();
    end else if (m_rem == 1) begin
      m_busy = 0;
      m_load(m_prod);
    end else begin
      m_rem--;
      m_bubble();
    end
  endtask

  task automatic compare_regs();
    check("out_valid",      out_valid,      e_valid);
    check("ctrl_reg",       ctrl_reg,       e_ctrl);
    check("alu_out_reg",    alu_out_reg,    e_alu);
    check("write_data_reg", write_data_reg, e_wd);
    check("dmem_info_reg",  dmem_info_reg,  e_info);
    check("write_reg_reg",  write_reg_reg,  e_wr);
  endtask

  // One clock: inputs were set at the preceding negedge. Checks the
  // combinational stall, advances the model, then checks registers.
  task automatic cycle(output bit st);
    #1;
    st = m_stall();
    check("stall_out", stall_out, st);
    m_step();
    @(posedge clk);
    @(negedge clk);
    compare_regs();
  endtask

  task automatic set_instr(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] sd,
                           input logic [CW-1:0] c, input logic [2:0] di, input logic [4:0] wr);
    in_valid = v; alu_op = op; op_a = a; op_b = b; store_data = sd;
    ctrl = c; dmem_info = di; write_reg = wr;
  endtask

  // Run until the presented instruction is accepted (stall low), with an
  // optional hold window starting at cycle hold_at.
  task automatic run_accept(input int hold_at, input int hold_len,
                            output int ncyc, output int nstall, output int nvalid);
    bit st;
    bit ok = 0;
    ncyc = 0; nstall = 0; nvalid = 0;
    for (int k = 0; k < 200; k++) begin
      hold = (k >= hold_at) && (k < hold_at + hold_len);
      cycle(st);
      ncyc++;
      if (st) nstall++;
      if (out_valid) nvalid++;
      if (!st) begin ok = 1; break; end
    end
    hold = 0;
    if (!ok) check("accept_timeout", 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nc, ns, nv;
    bit st;
    m_reset();
    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    compare_regs();
    check("rst_stall", stall_out, 0);
    rst_n = 1;
    @(negedge clk);

    // ADD overflow wrap with pass-through fields
    set_instr(1, ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 9'h010, 3'b000, 5'd5);
    cycle(st);
    check("add_res",   alu_out_reg,   32'h8000_0000);
    check("add_ctrl",  ctrl_reg,      9'h010);
    check("add_wr",    write_reg_reg, 5'd5);
    check("add_valid", out_valid,     1);
    check("add_stall", st,            0);

    set_instr(1, SRA, 32'h8000_0000, 32'h24, 0, 0, 0, 1);
    cycle(st);
    check("sra_res", alu_out_reg, 32'hF800_0000);
    set_instr(1, SLT, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 2);
    cycle(st);
    check("slt_res", alu_out_reg, 32'h1);
    set_instr(1, SLTU, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 3);
    cycle(st);
    check("sltu_res", alu_out_reg, 32'h0);

    // Multiply: W+1 cycles, W stalled, one valid result
    set_instr(1, MUL, 32'hFFFF_FFFF, 32'h3, 32'h55, 9'h003, 3'b010, 5'd7);
    run_accept(-1, 0, nc, ns, nv);
    check("mul_cycles", nc, W + 1);
    check("mul_stalls", ns, W);
    check("mul_nvalid", nv, 1);
    check("mul_res",    alu_out_reg, 32'hFFFF_FFFD);
    check("mul_wr",     write_reg_reg, 5'd7);
    set_instr(1, ADD, 32'h1, 32'h1, 0, 0, 0, 4);
    cycle(st);
    check("post_mul_add", alu_out_reg, 32'h2);

    // Multiply with a 3-cycle hold at iteration 10
    set_instr(1, MUL, 32'd12, 32'd13, 0, 0, 0, 8);
    run_accept(11, 3, nc, ns, nv);
    check("mulh_cycles", nc, W + 4);
    check("mulh_nvalid", nv, 1);
    check("mulh_res",    alu_out_reg, 32'd156);

    // Store held for two cycles: EX/MEM keeps the multiply result
    set_instr(1, ADD, 32'h100, 32'h8, 32'hDEAD_BEEF, 9'h010, 3'b011, 5'd0);
    hold = 1;
    cycle(st);
    check("st_hold_res1", alu_out_reg, 32'd156);
    cycle(st);
    check("st_hold_res2", alu_out_reg, 32'd156);
    hold = 0;
    cycle(st);
    check("st_addr", alu_out_reg,    32'h108);
    check("st_data", write_data_reg, 32'hDEAD_BEEF);
    check("st_info", dmem_info_reg,  3'b011);
    check("st_ctrl", ctrl_reg,       9'h010);

    // Reset in the middle of a multiply (after iteration 16 starts)
    set_instr(1, MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 9'h1FF, 0, 9);
    for (int k = 0; k < 17; k++) cycle(st);
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 0;
    m_reset();
    #1;
    compare_regs();
    check("rst_mid_stall", stall_out, 0);
    @(negedge clk);
    rst_n = 1;
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      cycle(st);
      if (out_valid) nv++;
    end
    check("rst_mid_noresult", nv, 0);

    // Randomized traffic; new instruction only once the last was accepted
    st = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!st) begin
        logic [W-1:0] a, b;
        int mode;
        mode = $urandom_range(0, 7);
        a = (mode == 0) ? 32'h0 : (mode == 1) ? 32'hFFFF_FFFF : (mode == 2) ? 32'h8000_0000 : $urandom;
        b = (mode == 3) ? 32'h0 : (mode == 4) ? a : $urandom;
        set_instr(($urandom % 5) != 0, 4'($urandom), a, b, $urandom,
                  CW'($urandom), 3'($urandom), 5'($urandom));
      end
      hold = ($urandom % 10) == 0;
      cycle(st);
    end
    hold = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline, directly upstream of the memory stage.
- Performs single-cycle ALU ops and an iterative multi-cycle multiply.
- Registers the result, store data, control, dmem size info and destination register into the EX/MEM pipeline register.
- Drives a stall request to earlier stages while a multiply is in flight or the memory stage holds the pipe.

Parameters:
- WIDTH, 32, datapath width. Also the multiply iteration count.
- CTRL_W, 9, control bundle width, passed through unmodified.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- hold  in  1  downstream lock; when 1, EX/MEM register and FSM freeze
- in_valid  in  1  ID/EX holds a real instruction; 0 = bubble
- alu_op  in  4  operation select (encoding in package)
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B (register or extended immediate)
- store_data  in  WIDTH  rs2 value for stores
- ctrl  in  CTRL_W  control bundle (bit 4 = dmem write enable)
- dmem_info  in  3  load/store sign and size info
- write_reg  in  5  destination register number
- stall_out  out  1  upstream must hold ID/EX and earlier stages
- out_valid  out  1  EX/MEM holds a real instruction
- ctrl_reg  out  CTRL_W  registered ctrl; forced 0 on bubble
- alu_out_reg  out  WIDTH  registered result (dmem address for loads/stores)
- write_data_reg  out  WIDTH  registered store_data
- dmem_info_reg  out  3  registered dmem_info
- write_reg_reg  out  5  registered write_reg

Behaviour:
- Reset (async, rst_n=0):
  - All registered outputs go to 0.
  - FSM goes to IDLE; iteration counter goes to 0.
  - stall_out follows its equation, which is 0 with hold=0.
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA
  - 8 SLT (signed), 9 SLTU, 10 SEQ, 11 SNE, 12 PASSB, 13 MUL
  - 14-15 are undefined and produce result 0.
- Arithmetic rules:
  - ADD/SUB/MUL wrap modulo 2^WIDTH.
  - Shift amount = low 5 bits of op_b.
  - Compare ops yield 1 or 0, zero-extended.
  - MUL yields the low WIDTH bits of op_a*op_b (same for signed and unsigned).
- FSM states: IDLE, MUL_RUN.
- IDLE, hold=0:
  - in_valid=1, non-MUL: next edge loads the EX/MEM register with the result and all pass-through fields; out_valid=1. Latency 1 cycle.
  - in_valid=0: next edge loads a bubble (out_valid=0, ctrl_reg=0, other fields 0).
  - in_valid=1, alu_op=MUL:
    - stall_out=1 combinationally this cycle.
    - Next edge captures the operands into the multiplier, clears the counter, moves to MUL_RUN, and loads a bubble into EX/MEM.
- MUL_RUN, hold=0:
  - One shift-add iteration per cycle; counter increments.
  - stall_out=1 while counter != WIDTH-1.
  - EX/MEM loads a bubble each edge except the last.
  - On the edge with counter=WIDTH-1: EX/MEM loads the product plus the (held) pass-through fields with out_valid=1; FSM returns to IDLE.
  - stall_out is 0 in that final cycle, so upstream advances on the same edge.
- MUL totals:
  - Occupies WIDTH+1 cycles from first presentation to result registered.
  - Upstream stalled WIDTH cycles.
  - Exactly one valid output.
- stall_out equation: hold | (IDLE & in_valid & alu_op==MUL) | (MUL_RUN & counter!=WIDTH-1).
- hold=1 (any state):
  - EX/MEM registers, FSM, counter and multiplier state are all unchanged.
  - Resume is exact; no iteration is lost or duplicated.
- Pass-through fields (ctrl, store_data, dmem_info, write_reg) are sampled at the edge that writes the valid result. Upstream keeps them stable while stall_out=1.
- Reset mid-multiply aborts it: no result, IDLE.
- MUL with either operand 0 still takes the full WIDTH iterations; no early exit.

Decomposition:
- Shared package (pipeline-wide):
  - alu_op encodings
  - WIDTH and CTRL_W defaults
  - ctrl bit index names (e.g. dmem write enable = 4)
- Sub-module mul_iter: start/busy/done, radix-2 shift-add multiplier, WIDTH-bit operands, low-half product, own counter.
- The ALU is combinational logic inside ex_stage.

Test Plan:
- Reset, then ADD with op_a=0x7FFFFFFF, op_b=1, ctrl=0x010, write_reg=5 -> after 1 edge: alu_out_reg=0x80000000, ctrl_reg=0x010, write_reg_reg=5, out_valid=1, stall_out=0.
- SRA op_a=0x80000000, op_b=0x24 (shift 4) -> 0xF8000000. SLT op_a=0xFFFFFFFF, op_b=0 -> 1. SLTU with the same operands -> 0.
- MUL op_a=0xFFFFFFFF, op_b=3 -> stall_out high 32 cycles, 32 bubbles, then alu_out_reg=0xFFFFFFFD, out_valid=1 exactly once. The next instruction (ADD 1+1) appears the following edge as 2.
- MUL 12*13 with hold pulsed high for 3 cycles at iteration 10 -> result 156 appears 3 cycles later than without hold. Outputs stay frozen during hold.
- Store (ctrl bit4=1, op_a=0x100, op_b=8, store_data=0xDEADBEEF, dmem_info=3'b011) with hold=1 for 2 cycles -> registers unchanged until hold drops, then alu_out_reg=0x108, write_data_reg=0xDEADBEEF, dmem_info_reg=3'b011.
- rst_n low at MUL iteration 16 -> outputs immediately 0, state IDLE, stall_out=0. No product is ever emitted.
